// File: rtl/sseg_pkg.sv
// Shared types and constants for the 4-digit 7-segment scan controller.
package sseg_pkg;

    typedef enum logic [1:0] {
        IDLE,
        BLANK,
        SHOW
    } scan_state_e;

    localparam int         NUM_DIGITS = 4;
    localparam logic [3:0] AN_OFF     = 4'b1111;
    localparam logic [6:0] SEG_OFF    = 7'b1111111;

    // A digit above 0 is dark when it and every more significant nibble are zero.
    function automatic logic digitBlanked(input logic [15:0] val,
                                          input logic [1:0]  k,
                                          input logic        lz);
        return lz && (k != 2'd0) && ((val >> {k, 2'b00}) == 16'h0000);
    endfunction

endpackage

// File: rtl/sseg_scan_ctrl_if.sv
// Host-side and display-side signals of the scan controller.
interface sseg_scan_ctrl_if;

    logic        enable;
    logic        load;
    logic [15:0] value;
    logic [3:0]  dp_mask;
    logic        lz_blank;
    logic [3:0]  an;
    logic [6:0]  sseg;
    logic        dp;
    logic        frame_done;

    modport master (
        output enable, load, value, dp_mask, lz_blank,
        input  an, sseg, dp, frame_done
    );

    modport slave (
        input  enable, load, value, dp_mask, lz_blank,
        output an, sseg, dp, frame_done
    );

endinterface

// File: rtl/sseg_driver.sv
// Hex nibble to active-low 7-segment decoder; sseg_o[0]=a .. sseg_o[6]=g.
module sseg_driver
    import sseg_pkg::*;
(
    input  logic [3:0] nibble_i,
    input  logic       dp_i,
    output logic [6:0] sseg_o,
    output logic       dp_o
);

    always_comb begin
        sseg_o = SEG_OFF;
        case (nibble_i)
            4'h0: sseg_o = 7'b1000000;
            4'h1: sseg_o = 7'b1111001;
            4'h2: sseg_o = 7'b0100100;
            4'h3: sseg_o = 7'b0110000;
            4'h4: sseg_o = 7'b0011001;
            4'h5: sseg_o = 7'b0010010;
            4'h6: sseg_o = 7'b0000010;
            4'h7: sseg_o = 7'b1111000;
            4'h8: sseg_o = 7'b0000000;
            4'h9: sseg_o = 7'b0010000;
            4'hA: sseg_o = 7'b0001000;
            4'hB: sseg_o = 7'b0000011;
            4'hC: sseg_o = 7'b1000110;
            4'hD: sseg_o = 7'b0100001;
            4'hE: sseg_o = 7'b0000110;
            4'hF: sseg_o = 7'b0001110;
            default: sseg_o = SEG_OFF;
        endcase
    end

    assign dp_o = dp_i;

endmodule

// File: rtl/sseg_scan_ctrl.sv
// Time-multiplexed scan controller for a 4-digit common-anode display with
// tear-free loading, leading-zero blanking and anti-ghost blank cycles.
module sseg_scan_ctrl
    import sseg_pkg::*;
#(
    parameter int PRESCALE     = 100000,
    parameter int BLANK_CYCLES = 4
) (
    input  logic            clk,
    input  logic            rst_n,
    sseg_scan_ctrl_if.slave bus
);

    localparam int               CNT_W       = $clog2(PRESCALE);
    localparam logic [CNT_W-1:0] BLANK_LAST  = CNT_W'(BLANK_CYCLES - 1);
    localparam logic [CNT_W-1:0] SLOT_PENULT = CNT_W'(PRESCALE - 2);
    localparam logic [CNT_W-1:0] SLOT_LAST   = CNT_W'(PRESCALE - 1);
    localparam logic [1:0]       DIGIT_LAST  = 2'(NUM_DIGITS - 1);

    scan_state_e      state_q;
    logic [1:0]       digit_q;
    logic [CNT_W-1:0] slotCnt_q;
    logic [3:0]       an_q;
    logic             dp_q;
    logic             frameDone_q;
    logic [3:0]       num_q;

    logic [15:0]      activeVal_q, activeVal_d;
    logic [3:0]       activeDp_q, activeDp_d;
    logic [15:0]      shadowVal_q, shadowVal_d;
    logic [3:0]       shadowDp_q, shadowDp_d;
    logic             pending_q, pending_d;

    logic             wrap;
    logic             commit;
    logic [1:0]       digitNext;
    logic             showBlank;
    logic [3:0]       showAn;
    logic [6:0]       segRaw;
    logic             unused_drvDp;

    assign wrap      = (state_q == SHOW) && (slotCnt_q == SLOT_LAST) && (digit_q == DIGIT_LAST);
    assign commit    = (state_q != IDLE) && (wrap || !bus.enable);
    assign digitNext = digit_q + 2'd1;
    assign showBlank = digitBlanked(activeVal_d, digit_q, bus.lz_blank);
    assign showAn    = AN_OFF & ~(4'b0001 << digit_q);

    // Frame boundaries and the drop into IDLE are the only points where the
    // displayed value may change; a load arriving at that moment wins outright.
    always_comb begin
        activeVal_d = activeVal_q;
        activeDp_d  = activeDp_q;
        shadowVal_d = shadowVal_q;
        shadowDp_d  = shadowDp_q;
        pending_d   = pending_q;
        if (state_q == IDLE) begin
            if (bus.load) begin
                activeVal_d = bus.value;
                activeDp_d  = bus.dp_mask;
            end
        end else if (commit) begin
            if (bus.load) begin
                activeVal_d = bus.value;
                activeDp_d  = bus.dp_mask;
            end else if (pending_q) begin
                activeVal_d = shadowVal_q;
                activeDp_d  = shadowDp_q;
            end
            pending_d = 1'b0;
        end else if (bus.load) begin
            shadowVal_d = bus.value;
            shadowDp_d  = bus.dp_mask;
            pending_d   = 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            activeVal_q <= '0;
            activeDp_q  <= '0;
            shadowVal_q <= '0;
            shadowDp_q  <= '0;
            pending_q   <= 1'b0;
        end else begin
            activeVal_q <= activeVal_d;
            activeDp_q  <= activeDp_d;
            shadowVal_q <= shadowVal_d;
            shadowDp_q  <= shadowDp_d;
            pending_q   <= pending_d;
        end
    end

    // num is loaded on BLANK entry so the decoder settles while all anodes are off.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q     <= IDLE;
            digit_q     <= '0;
            slotCnt_q   <= '0;
            an_q        <= AN_OFF;
            dp_q        <= 1'b1;
            frameDone_q <= 1'b0;
            num_q       <= '0;
        end else begin
            frameDone_q <= bus.enable && (state_q != IDLE) &&
                           (digit_q == DIGIT_LAST) && (slotCnt_q == SLOT_PENULT);
            if (!bus.enable) begin
                state_q   <= IDLE;
                digit_q   <= '0;
                slotCnt_q <= '0;
                an_q      <= AN_OFF;
                dp_q      <= 1'b1;
            end else begin
                case (state_q)
                    IDLE: begin
                        state_q   <= BLANK;
                        digit_q   <= '0;
                        slotCnt_q <= '0;
                        num_q     <= activeVal_d[3:0];
                        an_q      <= AN_OFF;
                        dp_q      <= 1'b1;
                    end
                    BLANK: begin
                        slotCnt_q <= slotCnt_q + CNT_W'(1);
                        if (slotCnt_q == BLANK_LAST) begin
                            state_q <= SHOW;
                            an_q    <= showBlank ? AN_OFF : showAn;
                            dp_q    <= showBlank | ~activeDp_d[digit_q];
                        end
                    end
                    SHOW: begin
                        if (slotCnt_q == SLOT_LAST) begin
                            state_q   <= BLANK;
                            slotCnt_q <= '0;
                            digit_q   <= digitNext;
                            num_q     <= activeVal_d[{digitNext, 2'b00} +: 4];
                            an_q      <= AN_OFF;
                            dp_q      <= 1'b1;
                        end else begin
                            slotCnt_q <= slotCnt_q + CNT_W'(1);
                        end
                    end
                    default: begin
                        state_q <= IDLE;
                    end
                endcase
            end
        end
    end

    sseg_driver u_driver (
        .nibble_i (num_q),
        .dp_i     (1'b1),
        .sseg_o   (segRaw),
        .dp_o     (unused_drvDp)
    );

    assign bus.an         = an_q;
    assign bus.dp         = dp_q;
    assign bus.frame_done = frameDone_q;
    assign bus.sseg       = segRaw;

endmodule

// File: tb/tb_sseg_scan_ctrl.sv
// Directed bench for sseg_scan_ctrl with PRESCALE=8, BLANK_CYCLES=2 (32-cycle frames).
module tb_sseg_scan_ctrl;

    localparam logic [6:0] S0 = 7'b1000000;
    localparam logic [6:0] S1 = 7'b1111001;
    localparam logic [6:0] S2 = 7'b0100100;
    localparam logic [6:0] S3 = 7'b0110000;
    localparam logic [6:0] S4 = 7'b0011001;
    localparam logic [6:0] S5 = 7'b0010010;
    localparam logic [6:0] S6 = 7'b0000010;
    localparam logic [6:0] S7 = 7'b1111000;
    localparam logic [6:0] S8 = 7'b0000000;
    localparam logic [6:0] SA = 7'b0001000;
    localparam logic [6:0] SB = 7'b0000011;
    localparam logic [6:0] SC = 7'b1000110;
    localparam logic [6:0] SD = 7'b0100001;

    logic clk;
    logic rst_n;
    int   testsRun;
    int   failCount;

    sseg_scan_ctrl_if bus ();

    sseg_scan_ctrl #(
        .PRESCALE     (8),
        .BLANK_CYCLES (2)
    ) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #100000;
        $display("[TB] FAIL watchdog: simulation time %0t exceeded limit", $time);
        $fatal(1, "[TB] timeout");
    end

    task automatic checkOutput(input string tag, input logic [31:0] observed,
                               input logic [31:0] expected);
        testsRun++;
        if (observed !== expected) begin
            failCount++;
            $display("[TB] FAIL %s: got %0h, expected %0h", tag, observed, expected);
        end
    endtask

    task automatic applyStimulus(input logic en, input logic ld, input logic [15:0] val,
                                 input logic [3:0] dpm, input logic lz);
        bus.enable   = en;
        bus.load     = ld;
        bus.value    = val;
        bus.dp_mask  = dpm;
        bus.lz_blank = lz;
    endtask

    // Checks one full frame starting at digit 0's first blank cycle; segs = {d3,d2,d1,d0}.
    task automatic checkFrame(input string tag, input logic [27:0] segs, input logic [3:0] lit,
                              input logic [3:0] dpm, input int loadAt, input logic [15:0] ldVal,
                              input logic [3:0] ldDp, input logic ldLz);
        int         digit;
        int         pos;
        logic       show;
        logic [3:0] expAn;
        logic       expDp;
        logic [6:0] expSeg;
        for (int c = 1; c <= 32; c++) begin
            @(negedge clk);
            digit  = (c - 1) / 8;
            pos    = (c - 1) % 8;
            show   = (pos >= 2) && lit[digit];
            expAn  = show ? ~(4'b0001 << digit) : 4'b1111;
            expDp  = show ? ~dpm[digit] : 1'b1;
            expSeg = segs[digit*7 +: 7];
            checkOutput($sformatf("%s c%0d an", tag, c), 32'(bus.an), 32'(expAn));
            checkOutput($sformatf("%s c%0d dp", tag, c), 32'(bus.dp), 32'(expDp));
            checkOutput($sformatf("%s c%0d frame_done", tag, c), 32'(bus.frame_done),
                        32'(c == 32));
            if (show)
                checkOutput($sformatf("%s c%0d sseg", tag, c), 32'(bus.sseg), 32'(expSeg));
            if (c == 1)
                checkOutput($sformatf("%s pending at frame start", tag), 32'(dut.pending_q), 32'd0);
            if (c == loadAt)
                applyStimulus(1'b1, 1'b1, ldVal, ldDp, ldLz);
            else
                bus.load = 1'b0;
        end
    endtask

    initial begin
        testsRun  = 0;
        failCount = 0;
        rst_n     = 1'b0;
        applyStimulus(1'b0, 1'b0, 16'h0000, 4'h0, 1'b0);
        repeat (3) @(negedge clk);
        checkOutput("reset an", 32'(bus.an), 32'hF);
        checkOutput("reset dp", 32'(bus.dp), 32'd1);
        checkOutput("reset frame_done", 32'(bus.frame_done), 32'd0);
        checkOutput("reset sseg", 32'(bus.sseg), 32'(S0));
        checkOutput("reset pending", 32'(dut.pending_q), 32'd0);

        rst_n = 1'b1;
        @(negedge clk);
        checkOutput("idle an", 32'(bus.an), 32'hF);

        applyStimulus(1'b1, 1'b1, 16'h1234, 4'h0, 1'b0);
        checkFrame("f1 1234", {S1, S2, S3, S4}, 4'b1111, 4'b0000, 12, 16'hABCD, 4'h0, 1'b0);
        checkFrame("f2 ABCD", {SA, SB, SC, SD}, 4'b1111, 4'b0000, 32, 16'h0000, 4'h0, 1'b1);
        checkFrame("f3 0000 lz", {S0, S0, S0, S0}, 4'b0001, 4'b0000, 5, 16'h0050, 4'h0, 1'b1);
        checkFrame("f4 0050 lz", {S0, S0, S5, S0}, 4'b0011, 4'b0000, 32, 16'h1234, 4'b0100, 1'b0);

        for (int c = 1; c <= 20; c++) begin
            @(negedge clk);
            if (c == 19)
                applyStimulus(1'b1, 1'b1, 16'h5678, 4'b0100, 1'b0);
            else
                bus.load = 1'b0;
        end
        checkOutput("digit2 show an", 32'(bus.an), 32'(4'b1011));
        checkOutput("digit2 show dp", 32'(bus.dp), 32'd0);
        checkOutput("digit2 show sseg", 32'(bus.sseg), 32'(S2));
        checkOutput("digit2 pending", 32'(dut.pending_q), 32'd1);

        applyStimulus(1'b0, 1'b0, 16'h0000, 4'h0, 1'b0);
        @(negedge clk);
        checkOutput("disable an", 32'(bus.an), 32'hF);
        checkOutput("disable dp", 32'(bus.dp), 32'd1);
        checkOutput("disable frame_done", 32'(bus.frame_done), 32'd0);
        checkOutput("disable pending", 32'(dut.pending_q), 32'd0);
        repeat (3) @(negedge clk);
        checkOutput("dark an", 32'(bus.an), 32'hF);

        applyStimulus(1'b1, 1'b0, 16'h0000, 4'h0, 1'b0);
        checkFrame("f6 5678 dp2", {S5, S6, S7, S8}, 4'b1111, 4'b0100, 0, 16'h0000, 4'h0, 1'b0);

        $display("[TB] %0d tests run, %0d failed", testsRun, failCount);
        $finish;
    end

endmodule
